if_id_pipe_reg: RTL and testbench

//  Parametrised IF/ID pipeline stage: latches fetched instruction word + PC between fetch and decode.

---
 rtl/cpu_types_pkg.sv | 103 ++++++++++
 rtl/if_id_pipe_reg.sv | 178 +++++++++++++++++
 tb/tb_if_id_pipe_reg.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared MIPS datapath types.
//   opcode_t / funct_t / regbits_t  - instruction field types used by decode
//   ifid_entry_t                    - default-width {instr, pc} pair held by the IF/ID stage
//   ifid_state_t                    - IF/ID occupancy state (EMPTY, ONE, TWO)
//   ifid_fields_t + decode_fields() - field slicing of a 32-bit MIPS word
package cpu_types_pkg;

    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;

    // Word used for reset, flush and bubbles: sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [OP_W-1:0] {
        OP_RTYPE = 6'h00,
        OP_REGIMM = 6'h01,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_BLEZ  = 6'h06,
        OP_BGTZ  = 6'h07,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_LBU   = 6'h24,
        OP_LHU   = 6'h25,
        OP_SB    = 6'h28,
        OP_SH    = 6'h29,
        OP_SW    = 6'h2B,
        OP_LL    = 6'h30,
        OP_SC    = 6'h38,
        OP_HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [FUNCT_W-1:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_SRA  = 6'h03,
        FN_SLLV = 6'h04,
        FN_SRLV = 6'h06,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef logic [REG_W-1:0] regbits_t;

    // Default-width stage entry; the stage re-declares it locally when
    // WORD_W / PC_W are overridden.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ifid_entry_t;

    // EMPTY: nothing live. ONE: head live. TWO: head + skid live (skid build only).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ifid_state_t;

    typedef struct packed {
        opcode_t          opcode;
        regbits_t         rs;
        regbits_t         rt;
        regbits_t         rd;
        logic [4:0]       shamt;
        funct_t           funct;
        logic [IMM_W-1:0] imm16;
    } ifid_fields_t;

    // Slice a MIPS word into its R/I-type fields; every field is reported
    // regardless of instruction format, decode picks what it needs.
    function automatic ifid_fields_t decode_fields(input logic [31:0] word);
        ifid_fields_t f;
        f.opcode = opcode_t'(word[31:26]);
        f.rs     = word[25:21];
        f.rt     = word[20:16];
        f.rd     = word[15:11];
        f.shamt  = word[10:6];
        f.funct  = funct_t'(word[5:0]);
        f.imm16  = word[15:0];
        return f;
    endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline stage between fetch/icache and decode.
// Holds the fetched word and its PC, exposes the decoded MIPS fields of the
// head entry, and supports stall back-pressure and flush-to-bubble.
// Build option: define IF_ID_SKID_EN to add a skid entry behind the head so
// that ready_out is a register with no combinational path from ready_in.
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready are
// both high (in_fire = valid_in & ready_out, out_fire = valid_out & ready_in).
// A valid source keeps its data stable until the transfer; valid never waits
// on ready. The stage never drops or reorders entries except on flush.
module if_id_pipe_reg
    import cpu_types_pkg::*;
#(
    parameter int                WORD_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [WORD_W-1:0] NOP_WORD = WORD_W'(NOP_INSTR)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [PC_W-1:0]   pc_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [WORD_W-1:0] instr_out,
    output logic [PC_W-1:0]   pc_out,
    output opcode_t           opcode_out,
    output regbits_t          rs_out,
    output regbits_t          rt_out,
    output regbits_t          rd_out,
    output logic [4:0]        shamt_out,
    output funct_t            funct_out,
    output logic [15:0]       imm16_out,
    output ifid_state_t       state_dbg
);

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [PC_W-1:0]   pc;
    } entry_t;

    localparam entry_t NOP_ENTRY = '{instr: NOP_WORD, pc: {PC_W{1'b0}}};

    ifid_state_t  state_q, state_d;
    entry_t       head_q, head_d;
    logic         valid_q, valid_d;
    entry_t       in_entry;
    logic         in_fire;
    logic         out_fire;
    ifid_fields_t fields;

`ifdef IF_ID_SKID_EN
    entry_t skid_q, skid_d;
    logic   rdy_q, rdy_d;

    // Registered ready: accept whenever the skid slot is free
    assign ready_out = rdy_q;
`else
    // Single entry: accept when empty or when the head leaves this cycle
    assign ready_out = ~valid_q | ready_in;
`endif

    assign in_fire   = valid_in & ready_out;
    assign out_fire  = valid_q & ready_in;
    assign in_entry  = '{instr: instr_in, pc: pc_in};

    assign valid_out = valid_q;
    assign instr_out = head_q.instr;
    assign pc_out    = head_q.pc;
    assign state_dbg = state_q;

    // Decoded fields come only from the head register, never from instr_in
    assign fields     = decode_fields(head_q.instr[31:0]);
    assign opcode_out = fields.opcode;
    assign rs_out     = fields.rs;
    assign rt_out     = fields.rt;
    assign rd_out     = fields.rd;
    assign shamt_out  = fields.shamt;
    assign funct_out  = fields.funct;
    assign imm16_out  = fields.imm16;

    // Next-state: occupancy transitions, data movement and flush priority
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        valid_d = valid_q;
`ifdef IF_ID_SKID_EN
        skid_d  = skid_q;
        rdy_d   = rdy_q;
`endif
        if (flush) begin
            // Flush wins over a same-cycle in_fire; a same-cycle out_fire
            // has already been taken by decode this cycle.
            state_d = EMPTY;
            head_d  = NOP_ENTRY;
            valid_d = 1'b0;
`ifdef IF_ID_SKID_EN
            skid_d  = NOP_ENTRY;
            rdy_d   = 1'b1;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        head_d  = in_entry;
                        valid_d = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
`ifdef IF_ID_SKID_EN
                    if (in_fire && out_fire) begin
                        head_d = in_entry;
                    end else if (in_fire) begin
                        // Head is stalled: park the new word in the skid slot
                        skid_d  = in_entry;
                        state_d = TWO;
                        rdy_d   = 1'b0;
                    end else if (out_fire) begin
                        head_d  = NOP_ENTRY;
                        valid_d = 1'b0;
                        state_d = EMPTY;
                    end
`else
                    if (in_fire) begin
                        // in_fire while full implies out_fire: replace head
                        head_d = in_entry;
                    end else if (out_fire) begin
                        head_d  = NOP_ENTRY;
                        valid_d = 1'b0;
                        state_d = EMPTY;
                    end
`endif
                end
`ifdef IF_ID_SKID_EN
                TWO: begin
                    // ready_out is low here, so only the head can move
                    if (out_fire) begin
                        head_d  = skid_q;
                        skid_d  = NOP_ENTRY;
                        state_d = ONE;
                        rdy_d   = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                    head_d  = NOP_ENTRY;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and data registers; reset discards everything immediately
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
            head_q  <= NOP_ENTRY;
            valid_q <= 1'b0;
`ifdef IF_ID_SKID_EN
            skid_q  <= NOP_ENTRY;
            rdy_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            valid_q <= valid_d;
`ifdef IF_ID_SKID_EN
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: self-checking bench for if_id_pipe_reg (either
// IF_ID_SKID_EN build). Expected stream is a queue of {instr, pc}; the
// stage's capacity and ready rule come from a plain occupancy model.
module tb_if_id_pipe_reg;
    import cpu_types_pkg::*;

    logic        clk;
    logic        nRST;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    opcode_t     opcode_out;
    regbits_t    rs_out;
    regbits_t    rt_out;
    regbits_t    rd_out;
    logic [4:0]  shamt_out;
    funct_t      funct_out;
    logic [15:0] imm16_out;
    ifid_state_t state_dbg;

    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [63:0] exp_q[$];

    if_id_pipe_reg dut (
        .CLK        (clk),
        .nRST       (nRST),
        .flush      (flush),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .instr_in   (instr_in),
        .pc_in      (pc_in),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .instr_out  (instr_out),
        .pc_out     (pc_out),
        .opcode_out (opcode_out),
        .rs_out     (rs_out),
        .rt_out     (rt_out),
        .rd_out     (rd_out),
        .shamt_out  (shamt_out),
        .funct_out  (funct_out),
        .imm16_out  (imm16_out),
        .state_dbg  (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Capacity model: one entry without skid, two with skid.
    function automatic logic model_rdy(input logic r);
`ifdef IF_ID_SKID_EN
        return exp_q.size() < 2;
`else
        return (exp_q.size() == 0) || r;
`endif
    endfunction

    // Driver: present inputs at negedge, then record what the stage accepted
    task automatic step(input logic v, input logic r, input logic f,
                        input logic [31:0] ins, input logic [31:0] pcv);
        logic acc;
        @(negedge clk);
        valid_in = v;
        ready_in = r;
        flush    = f;
        instr_in = ins;
        pc_in    = pcv;
        #1;
        acc = v && model_rdy(r);
        #2;
        if (f) exp_q.delete();
        else if (acc) exp_q.push_back({ins, pcv});
    endtask

    // Monitor: compare head against the scoreboard, pop on out_fire
    initial begin : monitor
        logic [63:0] e;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("ready_out", ready_out, model_rdy(ready_in));
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    w = e[63:32];
                    chk("valid_out", valid_out, 1);
                    chk("instr_out", instr_out, w);
                    chk("pc_out", pc_out, e[31:0]);
                    chk("opcode_out", opcode_out, w[31:26]);
                    chk("rs_out", rs_out, w[25:21]);
                    chk("rt_out", rt_out, w[20:16]);
                    chk("rd_out", rd_out, w[15:11]);
                    chk("shamt_out", shamt_out, w[10:6]);
                    chk("funct_out", funct_out, w[5:0]);
                    chk("imm16_out", imm16_out, w[15:0]);
                    if (ready_in) void'(exp_q.pop_front());
                end else begin
                    chk("bubble_valid", valid_out, 0);
                    chk("bubble_instr", instr_out, 0);
                    chk("bubble_pc", pc_out, 0);
                    chk("bubble_opcode", opcode_out, 0);
                    chk("bubble_funct", funct_out, 0);
                    chk("bubble_imm16", imm16_out, 0);
                end
            end
        end
    end

    // Stimulus sequence and final report
    initial begin : stimulus
        nRST = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        instr_in = '0; pc_in = '0;
        #2;
        chk("reset_valid", valid_out, 0);
        chk("reset_instr", instr_out, 0);
        chk("reset_pc", pc_out, 0);
        chk("reset_ready", ready_out, 1);
        @(negedge clk);
        nRST = 1'b1;
        mon_en = 1'b1;

        // Stream of 8 back-to-back words
        for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h8C22_0004 + i, 32'h0040_0004 + 4 * i);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Stall with add $1,$2,$3 at the head
        step(1, 1, 0, 32'h0043_0820, 32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 32'hAAAA_0000 + i, 32'h0000_0200 + 4 * i);
`ifdef IF_ID_SKID_EN
            chk("stall_ready", ready_out, (i == 0));
`else
            chk("stall_ready", ready_out, 0);
`endif
            chk("stall_instr", instr_out, 32'h0043_0820);
            chk("stall_rs", rs_out, 2);
            chk("stall_rt", rt_out, 3);
            chk("stall_rd", rd_out, 1);
            chk("stall_funct", funct_out, 6'h20);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

        // Flush with a word offered in the same cycle, decode stalled
        step(1, 1, 0, 32'h1000_FFFF, 32'h0000_0300);
        step(1, 0, 1, 32'h2000_0001, 32'h0000_0304);
        step(0, 1, 0, 0, 0);
        chk("flush_valid", valid_out, 0);
        chk("flush_instr", instr_out, 0);
        // Flush while decode takes the head; then flush while empty
        step(1, 1, 0, 32'h1000_FFFF, 32'h0000_0310);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);

        // Bubble: one word then nothing
        step(1, 1, 0, 32'h2108_1234, 32'h0000_0400);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("bubble_imm_after", imm16_out, 0);

        // Reset asserted mid-stream
        for (int i = 0; i < 3; i++) step(1, i != 1, 0, 32'h3C01_0000 + i, 32'h0000_0500 + 4 * i);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        nRST = 1'b0;
        #1;
        chk("midrst_valid", valid_out, 0);
        chk("midrst_instr", instr_out, 0);
        chk("midrst_pc", pc_out, 0);
        chk("midrst_ready", ready_out, 1);
        exp_q.delete();
        valid_in = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        mon_en = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, $urandom, $urandom);
        end
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        chk("drained", valid_out, 0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
